cpu_clock_ctrl: RTL and testbench



---
 rtl/cpu_clock_ctrl_if.sv | 33 +++
 rtl/cpu_clock_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if
// Control/status bundle between the debug front end (buttons, debug bus)
// and the CPU clock controller.
//   run_req/halt_req/step_req : state change requests
//   div_load/div_val/div_ack  : divide-ratio load and its one-cycle acknowledge
//   bp_en/bp_addr/pc          : PC breakpoint compare inputs
//   cpu_ce                    : one-cycle CPU clock-enable pulse
//   state/halted/cycle_cnt    : controller status
interface cpu_clock_ctrl_if;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic        div_load;
  logic [15:0] div_val;
  logic        div_ack;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        halted;
  logic [31:0] cycle_cnt;

  modport master (
    output run_req, halt_req, step_req, div_load, div_val, bp_en, bp_addr, pc,
    input  div_ack, cpu_ce, state, halted, cycle_cnt
  );

  modport slave (
    input  run_req, halt_req, step_req, div_load, div_val, bp_en, bp_addr, pc,
    output div_ack, cpu_ce, state, halted, cycle_cnt
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
// Run/step/halt controller producing a one-clk-cycle CPU clock enable at a
// programmable divide ratio, with single-step, halt and PC breakpoint.
// Ports:
//   clk  : board clock
//   rst  : asynchronous active-high reset
//   bus  : cpu_clock_ctrl_if.slave (requests, divider load, breakpoint,
//          cpu_ce and status outputs)
// state encoding: 0 HALT, 1 RUN, 2 STEP, 3 BRK.
module cpu_clock_ctrl #(
  parameter logic [15:0] DIV_DEFAULT  = 16'd5,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  cpu_clock_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

  // A zero divide ratio behaves as 1 (enable every cycle).
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  localparam logic [15:0] DIV_INIT  = clamp_div(DIV_DEFAULT);
  localparam state_t      RST_STATE = RUN_ON_RESET ? S_RUN : S_HALT;

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] div_q, div_n;
  logic        skip_q, skip_n;
  logic        ce_q, ce_n;
  logic        ack_q;
  logic        halted_q;
  logic [31:0] cyc_q;

  logic at_top;
  logic bp_hit;

  assign at_top = (cnt_q == div_q - 16'd1);
  assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && !skip_q;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    div_n   = div_q;
    skip_n  = skip_q;
    ce_n    = 1'b0;
    case (state_q)
      S_HALT, S_BRK: begin
        cnt_n = 16'd0;
        // halt_req outranks step/run, so it simply blocks them here.
        if (!bus.halt_req) begin
          if (bus.step_req) begin
            state_n = S_STEP;
            if (state_q == S_BRK) skip_n = 1'b1;
          end else if (bus.run_req) begin
            state_n = S_RUN;
            if (state_q == S_BRK) skip_n = 1'b1;
          end
        end
      end
      S_RUN, S_STEP: begin
        if (bus.halt_req) begin
          // Coincident fire is dropped: no pulse at or after the halt edge.
          state_n = S_HALT;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = at_top ? 16'd0 : cnt_q + 16'd1;
          // A divider load on the fire edge suppresses that pulse.
          if (at_top && !bus.div_load) begin
            if (state_q == S_RUN && bp_hit) begin
              state_n = S_BRK;
              cnt_n   = 16'd0;
            end else begin
              // The skipped instruction has now executed (RUN or STEP),
              // so the breakpoint is re-armed.
              ce_n   = 1'b1;
              skip_n = 1'b0;
              if (state_q == S_STEP) state_n = S_HALT;
            end
          end
        end
      end
      default: ;
    endcase
    if (bus.div_load) begin
      div_n = clamp_div(bus.div_val);
      cnt_n = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= 16'd0;
      div_q    <= DIV_INIT;
      skip_q   <= 1'b0;
      ce_q     <= 1'b0;
      ack_q    <= 1'b0;
      halted_q <= !RUN_ON_RESET;
      cyc_q    <= 32'd0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      div_q    <= div_n;
      skip_q   <= skip_n;
      ce_q     <= ce_n;
      ack_q    <= bus.div_load;
      halted_q <= (state_n == S_HALT) || (state_n == S_BRK);
      cyc_q    <= cyc_q + {31'd0, ce_n};
    end
  end

  assign bus.cpu_ce    = ce_q;
  assign bus.div_ack   = ack_q;
  assign bus.state     = state_q;
  assign bus.halted    = halted_q;
  assign bus.cycle_cnt = cyc_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl
// Directed bench for cpu_clock_ctrl (DIV_DEFAULT=5, RUN_ON_RESET=1).
// Scenarios run back to back from one initial block; each task drives its
// stimulus and checks the registered outputs 1 time unit after each edge.
module tb_cpu_clock_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cpu_clock_ctrl_if bus();

  cpu_clock_ctrl #(
    .DIV_DEFAULT  (16'd5),
    .RUN_ON_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %b want 0", bus.cpu_ce); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL rst_state got %0d want 1", bus.state); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", bus.halted); end
    checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_cyc got %0d want 0", bus.cycle_cnt); end
    checks++; if (bus.div_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", bus.div_ack); end
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (bus.cpu_ce !== ((k % 5) == 0)) begin
        errors++; $display("FAIL run_ce edge %0d got %b want %b", k, bus.cpu_ce, (k % 5) == 0);
      end
      checks++;
      if (bus.cycle_cnt !== 32'(k / 5)) begin
        errors++; $display("FAIL run_cyc edge %0d got %0d want %0d", k, bus.cycle_cnt, k / 5);
      end
    end
    tick();
    tick();
    // Mid-count asynchronous reset, checked before the next clock edge.
    rst = 1'b1;
    #1;
    checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL async_rst_cyc got %0d want 0", bus.cycle_cnt); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL async_rst_state got %0d want 1", bus.state); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL async_rst_ce got %b want 0", bus.cpu_ce); end
    rst = 1'b0;
  endtask

  task automatic test_step();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL halt_state got %0d want 0", bus.state); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b want 1", bus.halted); end
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL step_state0 got %0d want 2", bus.state); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (bus.cpu_ce !== (k == 5)) begin
        errors++; $display("FAIL step_ce edge %0d got %b want %b", k, bus.cpu_ce, k == 5);
      end
      checks++;
      if (bus.state !== ((k < 5) ? 2'd2 : 2'd0)) begin
        errors++; $display("FAIL step_state edge %0d got %0d want %0d", k, bus.state, (k < 5) ? 2 : 0);
      end
    end
    checks++; if (bus.cycle_cnt !== 32'd1) begin errors++; $display("FAIL step_cyc got %0d want 1", bus.cycle_cnt); end
  endtask

  task automatic test_breakpoint();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0040_0010;
    bus.pc      = 32'h0040_0010;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL bp_run_state got %0d want 1", bus.state); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL bp_ce edge %0d got %b want 0", k, bus.cpu_ce); end
    end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL bp_state got %0d want 3", bus.state); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL bp_halted got %b want 1", bus.halted); end
    // Resume: the breakpointed instruction must execute once.
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (bus.cpu_ce !== (k == 5)) begin
        errors++; $display("FAIL skip_ce edge %0d got %b want %b", k, bus.cpu_ce, k == 5);
      end
    end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL rebrk_state got %0d want 3", bus.state); end
    checks++; if (bus.cycle_cnt !== 32'd2) begin errors++; $display("FAIL bp_cyc got %0d want 2", bus.cycle_cnt); end
    bus.bp_en   = 1'b0;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
  endtask

  task automatic test_div_reload();
    tick();
    tick();
    tick();
    bus.div_load = 1'b1;
    bus.div_val  = 16'd0;
    tick();
    bus.div_load = 1'b0;
    checks++; if (bus.div_ack !== 1'b1) begin errors++; $display("FAIL div_ack got %b want 1", bus.div_ack); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL div_ce got %b want 0", bus.cpu_ce); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL div1_ce edge %0d got %b want 1", k, bus.cpu_ce); end
      checks++;
      if (bus.cycle_cnt !== 32'(2 + k)) begin
        errors++; $display("FAIL div1_cyc edge %0d got %0d want %0d", k, bus.cycle_cnt, 2 + k);
      end
    end
    checks++; if (bus.div_ack !== 1'b0) begin errors++; $display("FAIL div_ack_drop got %b want 0", bus.div_ack); end
  endtask

  task automatic test_priority();
    bus.div_load = 1'b1;
    bus.div_val  = 16'd5;
    tick();
    bus.div_load = 1'b0;
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL reload_ce got %b want 0", bus.cpu_ce); end
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL pre_fire_ce got %b want 0", bus.cpu_ce); end
    bus.halt_req = 1'b1;
    bus.step_req = 1'b1;
    bus.run_req  = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL prio_state got %0d want 0", bus.state); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL prio_ce got %b want 0", bus.cpu_ce); end
    checks++; if (bus.cycle_cnt !== 32'd6) begin errors++; $display("FAIL prio_cyc got %0d want 6", bus.cycle_cnt); end
    tick();
    bus.step_req = 1'b0;
    bus.run_req  = 1'b0;
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL prio_step got %0d want 2", bus.state); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (bus.cpu_ce !== (k == 5)) begin
        errors++; $display("FAIL prio_step_ce edge %0d got %b want %b", k, bus.cpu_ce, k == 5);
      end
    end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL prio_end_state got %0d want 0", bus.state); end
    checks++; if (bus.cycle_cnt !== 32'd7) begin errors++; $display("FAIL prio_end_cyc got %0d want 7", bus.cycle_cnt); end
  endtask

  task automatic test_wrap();
    bus.div_load = 1'b1;
    bus.div_val  = 16'd1;
    bus.run_req  = 1'b1;
    tick();
    bus.div_load = 1'b0;
    bus.run_req  = 1'b0;
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL wrap_state got %0d want 1", bus.state); end
    tick();
    checks++; if (bus.cycle_cnt !== 32'd8) begin errors++; $display("FAIL wrap_pre_cyc got %0d want 8", bus.cycle_cnt); end
    @(negedge clk);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    checks++; if (bus.cycle_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h want ffffffff", bus.cycle_cnt); end
    tick();
    checks++; if (bus.cycle_cnt !== 32'd0) begin errors++; $display("FAIL wrap_cyc got %h want 0", bus.cycle_cnt); end
    checks++; if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL wrap_ce got %b want 1", bus.cpu_ce); end
    tick();
    checks++; if (bus.cycle_cnt !== 32'd1) begin errors++; $display("FAIL wrap_next got %h want 1", bus.cycle_cnt); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = 16'd0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'd0;
    bus.pc       = 32'd0;
    test_reset();
    test_step();
    test_breakpoint();
    test_div_reload();
    test_priority();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
